mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single-port data memory.
//   Each granted access runs IDLE -> ISSUE -> WAIT -> IDLE: the memory strobe
//   is raised in ISSUE, the requester's ack is pulsed in WAIT, where read data
//   is forwarded from the memory.
//
// Ports
//   clock, reset_n             system clock, asynchronous active-low reset
//   req0/req1                  access requests (held until ack)
//   we0/we1                    1 = write, 0 = read (sampled with request)
//   addr0/addr1                word address (sampled with request)
//   wdata0/wdata1              write data (sampled with request)
//   ack0/ack1                  one-cycle completion pulse per requester
//   rdata                      read data, valid while ack is high, else held
//   busy                       high whenever the FSM is not IDLE
//   mem_en/mem_we              memory strobe / write qualifier
//   mem_addr/mem_wdata         memory address / write data
//   mem_rdata                  memory read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Requester granted most recently; resets to 1 so requester 0 wins the
  // first tie.
  logic last_q;
  logic win_d;

  // Transaction register: captured in IDLE, frozen until the next IDLE.
  logic              txn_who;
  logic              txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic any_req;
  assign any_req = req0 | req1;

  // Round-robin pick: a lone requester wins; on a tie the one not granted
  // last time wins.
  always_comb begin
    win_d = 1'b0;
    if (req0 && req1) win_d = ~last_q;
    else if (req1)    win_d = 1'b1;
  end

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= 1'b1;
      txn_who   <= 1'b0;
      txn_we    <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        txn_who   <= win_d;
        txn_we    <= win_d ? we1    : we0;
        txn_addr  <= win_d ? addr1  : addr0;
        txn_wdata <= win_d ? wdata1 : wdata0;
      end
      if (state_q == WAIT) begin
        last_q <= txn_who;
        if (!txn_we) rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decode registered state only; requests never reach them
  // combinationally. Address/data hold the last transaction between accesses.
  logic in_wait;
  assign in_wait   = (state_q == WAIT);

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & txn_we;
  assign mem_addr  = txn_addr;
  assign mem_wdata = txn_wdata;
  assign ack0      = in_wait & ~txn_who;
  assign ack1      = in_wait &  txn_who;
  // Read data is forwarded straight from memory during the ack cycle and the
  // captured copy is shown afterwards; writes leave it untouched.
  assign rdata     = (in_wait && !txn_we) ? mem_rdata : rdata_q;

endmodule
